// File: rtl/dmem_bridge_if.sv
// Bundles the core load/store port and the data-RAM port of the data-memory bridge.
// slave is the bridge's view, master is the view of whatever surrounds it.
interface dmem_bridge_if #(
    parameter int ADDR_W = 12
);
    logic              CORE_REQ;
    logic              CORE_WE;
    logic [2:0]        CORE_FUNCT3;
    logic [ADDR_W-1:0] CORE_ADDR;
    logic [31:0]       CORE_WDATA;
    logic [31:0]       CORE_RDATA;
    logic              CORE_STALL;
    logic              CORE_ERR;
    logic [ADDR_W-3:0] RAM_ADDRESS;
    logic [31:0]       RAM_DATA_IN;
    logic [31:0]       RAM_DATA_OUT;
    logic              RAM_OE;
    logic              RAM_WR;
    logic [3:0]        RAM_BE;

    // Handshake: the core raises CORE_REQ and holds every request field stable while
    // CORE_STALL=1; the access completes in the first cycle with CORE_REQ=1 and
    // CORE_STALL=0. CORE_ERR is a single-cycle reject with no RAM activity.
    modport slave (
        input  CORE_REQ, CORE_WE, CORE_FUNCT3, CORE_ADDR, CORE_WDATA, RAM_DATA_OUT,
        output CORE_RDATA, CORE_STALL, CORE_ERR, RAM_ADDRESS, RAM_DATA_IN, RAM_OE, RAM_WR, RAM_BE
    );

    modport master (
        output CORE_REQ, CORE_WE, CORE_FUNCT3, CORE_ADDR, CORE_WDATA, RAM_DATA_OUT,
        input  CORE_RDATA, CORE_STALL, CORE_ERR, RAM_ADDRESS, RAM_DATA_IN, RAM_OE, RAM_WR, RAM_BE
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: funct3 decode, lane steering, load extension, RAM wait states
// and read-modify-write for sub-word stores into a RAM without byte enables.
module dmem_bridge #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1,
    parameter bit RMW         = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_n,
    dmem_bridge_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  f3;
    logic [1:0]  lane;
    logic        f3_ok, align_ok, legal, sub_word;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane, lane_mask, merged, shifted, load_ext;

    logic        oe, wr, stall, err, load_done;
    logic [3:0]  be;
    logic [31:0] din;

    assign f3       = bus.CORE_FUNCT3;
    assign lane     = bus.CORE_ADDR[1:0];
    assign sub_word = (f3[1:0] != 2'd2);
    assign legal    = f3_ok && align_ok;

    always_comb begin
        if (bus.CORE_WE) f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else             f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                                 (f3 == 3'd4) || (f3 == 3'd5);
        case (f3[1:0])
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = !lane[0];
            default: align_ok = (lane == 2'd0);
        endcase
    end

    always_comb begin
        case (f3[1:0])
            2'd0: begin
                be_lane    = 4'b0001 << lane;
                wdata_lane = {4{bus.CORE_WDATA[7:0]}};
            end
            2'd1: begin
                be_lane    = 4'b0011 << lane;
                wdata_lane = {2{bus.CORE_WDATA[15:0]}};
            end
            default: begin
                be_lane    = 4'hF;
                wdata_lane = bus.CORE_WDATA;
            end
        endcase
    end

    assign lane_mask = {{8{be_lane[3]}}, {8{be_lane[2]}}, {8{be_lane[1]}}, {8{be_lane[0]}}};
    assign merged    = (bus.RAM_DATA_OUT & ~lane_mask) | (wdata_lane & lane_mask);
    assign shifted   = bus.RAM_DATA_OUT >> {lane, 3'b000};

    always_comb begin
        case (f3)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'h0, shifted[7:0]};
            3'd5:    load_ext = {16'h0, shifted[15:0]};
            default: load_ext = bus.RAM_DATA_OUT;
        endcase
    end

    // The counter holds the index of the current access cycle; the final read cycle
    // is the one where it equals WAIT_STATES. A dropped request always wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        oe        = 1'b0;
        wr        = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        load_done = 1'b0;
        be        = 4'h0;
        din       = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.CORE_REQ) begin
                    if (!legal) begin
                        err = 1'b1;
                    end else if (!bus.CORE_WE) begin
                        oe = 1'b1;
                        if (WAIT_STATES == 0) begin
                            load_done = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = 3'd1;
                            state_d = RD_WAIT;
                        end
                    end else if (sub_word && RMW) begin
                        oe    = 1'b1;
                        stall = 1'b1;
                        if (WAIT_STATES == 0) begin
                            merge_d = merged;
                            state_d = RMW_WR;
                        end else begin
                            cnt_d   = 3'd1;
                            state_d = RMW_WAIT;
                        end
                    end else begin
                        wr  = 1'b1;
                        be  = be_lane;
                        din = wdata_lane;
                    end
                end
            end
            RD_WAIT: begin
                if (!bus.CORE_REQ) begin
                    state_d = IDLE;
                end else begin
                    oe = 1'b1;
                    if (cnt_q == WS) begin
                        load_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            RMW_WAIT: begin
                if (!bus.CORE_REQ) begin
                    state_d = IDLE;
                end else begin
                    oe    = 1'b1;
                    stall = 1'b1;
                    if (cnt_q == WS) begin
                        merge_d = merged;
                        state_d = RMW_WR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            RMW_WR: begin
                state_d = IDLE;
                if (bus.CORE_REQ) begin
                    wr  = 1'b1;
                    be  = 4'hF;
                    din = merge_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_done) rdata_d = load_ext;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset masks the combinational paths too, so nothing reaches the RAM mid-reset.
    assign bus.CORE_STALL  = RST_n & stall;
    assign bus.CORE_ERR    = RST_n & err;
    assign bus.RAM_OE      = RST_n & oe;
    assign bus.RAM_WR      = RST_n & wr;
    assign bus.RAM_BE      = RST_n ? be : 4'h0;
    assign bus.RAM_DATA_IN = RST_n ? din : 32'h0;
    assign bus.RAM_ADDRESS = (RST_n && (oe || wr)) ? bus.CORE_ADDR[ADDR_W-1:2] : '0;
    assign bus.CORE_RDATA  = !RST_n ? 32'h0 : (load_done ? load_ext : rdata_q);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: three configurations share one stimulus bus, a RAM model that
// returns garbage until the read latency has elapsed, and a transaction-level reference.
module tb_dmem_bridge;
    localparam int AW   = 12;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req, we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            sel;

    logic [NCFG-1:0] stall_o, err_o, oe_o, wr_o;
    logic [31:0]     rdata_o  [NCFG];
    logic [9:0]      ram_addr [NCFG];
    logic [31:0]     ram_din  [NCFG];
    logic [31:0]     ram_dout [NCFG];
    logic [3:0]      ram_be   [NCFG];
    logic [1:0]      state_o  [NCFG];

    // cfg 0: 2 wait states with RMW; cfg 1: combinational RAM with byte enables; cfg 2: 1 wait state with RMW
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int WSG = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
        localparam bit RMG = (g != 1);
        dmem_bridge_if #(.ADDR_W(AW)) bus ();
        assign bus.CORE_REQ     = req && (sel == g);
        assign bus.CORE_WE      = we;
        assign bus.CORE_FUNCT3  = f3;
        assign bus.CORE_ADDR    = addr;
        assign bus.CORE_WDATA   = wdata;
        assign bus.RAM_DATA_OUT = ram_dout[g];
        assign stall_o[g]  = bus.CORE_STALL;
        assign err_o[g]    = bus.CORE_ERR;
        assign oe_o[g]     = bus.RAM_OE;
        assign wr_o[g]     = bus.RAM_WR;
        assign rdata_o[g]  = bus.CORE_RDATA;
        assign ram_addr[g] = bus.RAM_ADDRESS;
        assign ram_din[g]  = bus.RAM_DATA_IN;
        assign ram_be[g]   = bus.RAM_BE;
        dmem_bridge #(.ADDR_W(AW), .WAIT_STATES(WSG), .RMW(RMG)) dut (
            .CLK(clk), .RST_n(rst_n), .bus(bus.slave), .dbg_state(state_o[g])
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 0 : 1);
    endfunction

    function automatic bit rmw_of(input int g);
        return (g != 1);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // RAM model
    logic [31:0] mem [NCFG][1024];
    int          oe_cnt   [NCFG] = '{0, 0, 0};
    logic [9:0]  last_a   [NCFG] = '{10'd0, 10'd0, 10'd0};
    int          wr_count [NCFG] = '{0, 0, 0};
    logic        pre_we = 1'b0;
    int          pre_g  = 0;
    logic [9:0]  pre_a  = 10'd0;
    logic [31:0] pre_d  = 32'h0;

    always @(posedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (wr_o[g]) begin
                mem[g][ram_addr[g]] <= (mem[g][ram_addr[g]] & ~bmask(ram_be[g])) |
                                       (ram_din[g] & bmask(ram_be[g]));
                wr_count[g] <= wr_count[g] + 1;
            end
            if (oe_o[g]) begin
                oe_cnt[g] <= (ram_addr[g] == last_a[g]) ? oe_cnt[g] + 1 : 1;
                last_a[g] <= ram_addr[g];
            end else begin
                oe_cnt[g] <= 0;
            end
        end
        if (pre_we) mem[pre_g][pre_a] <= pre_d;
    end

    always_comb begin
        for (int g = 0; g < NCFG; g++) begin
            ram_dout[g] = 32'hDEAD_BEEF;
            if (oe_o[g] && (((ram_addr[g] == last_a[g]) ? oe_cnt[g] : 0) >= ws_of(g)))
                ram_dout[g] = mem[g][ram_addr[g]];
        end
    end

    // Reference state and per-cycle expectations
    logic [31:0] ref_mem [NCFG][1024];
    logic [31:0] hold    [NCFG];
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_err, exp_oe, exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_din, exp_rdata;
    logic [9:0]  exp_addr;
    int          n_chk = 0, n_fail = 0;
    int          stall_cnt = 0, err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall_o[sel], exp_stall);
            chk("err", err_o[sel], exp_err);
            chk("ram_oe", oe_o[sel], exp_oe);
            chk("ram_wr", wr_o[sel], exp_wr);
            chk("rdata", rdata_o[sel], exp_rdata);
            if (exp_oe || exp_wr) chk("ram_addr", ram_addr[sel], exp_addr);
            if (exp_wr) begin
                chk("ram_be", ram_be[sel], exp_be);
                chk("ram_din", ram_din[sel], exp_din);
            end
            if (stall_o[sel]) stall_cnt++;
            if (err_o[sel]) err_cnt++;
        end
    end

    task automatic clear_exp(input int g);
        exp_stall = 1'b0; exp_err = 1'b0; exp_oe = 1'b0; exp_wr = 1'b0;
        exp_be = 4'h0; exp_din = 32'h0; exp_addr = 10'd0;
        exp_rdata = hold[g];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            clear_exp(sel);
            chk_en = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input int g, input int wa, input logic [31:0] d);
        req = 1'b0;
        clear_exp(sel);
        pre_we = 1'b1; pre_g = g; pre_a = 10'(wa); pre_d = d;
        ref_mem[g][wa] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // One core access; abort_at >= 0 drops the request in that cycle of the access.
    task automatic access(input int g, input bit w, input logic [2:0] fn, input logic [11:0] a,
                          input logic [31:0] d, input int abort_at = -1);
        int ws, nb, lane, n;
        bit ok;
        logic [31:0] word, nw, rd, rep;
        logic [3:0] bm;
        ws   = ws_of(g);
        nb   = 1 << fn[1:0];
        lane = int'(a[1:0]);
        ok   = w ? (fn <= 3'd2) : (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (ok && (int'(a) % nb) != 0) ok = 1'b0;
        word = ref_mem[g][a[11:2]];
        nw   = word;
        rd   = 32'h0;
        if (ok) begin
            for (int k = 0; k < nb; k++) begin
                nw[8*(lane+k) +: 8] = d[8*k +: 8];
                rd[8*k +: 8]        = word[8*(lane+k) +: 8];
            end
            if (!w && !fn[2] && nb < 4 && rd[8*nb-1])
                for (int k = nb; k < 4; k++) rd[8*k +: 8] = 8'hFF;
        end
        rep = (nb == 1) ? {4{d[7:0]}} : ((nb == 2) ? {2{d[15:0]}} : d);
        bm  = 4'((1 << nb) - 1) << lane;
        if (!ok)                          n = 1;
        else if (!w)                      n = ws + 1;
        else if (nb == 4 || !rmw_of(g))   n = 1;
        else                              n = ws + 2;
        for (int i = 0; i < n; i++) begin
            sel = g; we = w; f3 = fn; addr = a; wdata = d; req = 1'b1;
            clear_exp(g);
            exp_addr = a[11:2];
            if (i == abort_at) begin
                req = 1'b0;
            end else if (!ok) begin
                exp_err = 1'b1;
            end else if (!w) begin
                exp_oe    = 1'b1;
                exp_stall = (i < ws);
                if (i == ws) exp_rdata = rd;
            end else if (n == 1) begin
                exp_wr = 1'b1; exp_be = bm; exp_din = rep;
            end else if (i <= ws) begin
                exp_oe = 1'b1; exp_stall = 1'b1;
            end else begin
                exp_wr = 1'b1; exp_be = 4'hF; exp_din = nw;
            end
            chk_en = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            if (i == abort_at) return;
        end
        if (ok && !w) hold[g] = rd;
        if (ok && w) ref_mem[g][a[11:2]] = nw;
    endtask

    int wc;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = '0; wdata = 32'h0; sel = 0;
        for (int g = 0; g < NCFG; g++) hold[g] = 32'h0;
        clear_exp(0);
        @(posedge clk);
        #1;
        preload(0, 0, 32'h80FF_7F01);
        preload(1, 0, 32'h80FF_7F01);
        preload(2, 0, 32'h1122_3344);
        preload(2, 3, 32'hCAFE_F00D);
        for (int k = 4; k < 12; k++) preload(2, k, (32'h0101_0101 * k) ^ 32'h8040_2010);
        for (int g = 0; g < NCFG; g++) begin
            chk("reset_stall", stall_o[g], 1'b0);
            chk("reset_rdata", rdata_o[g], 32'h0);
            chk("reset_state", state_o[g], 2'd0);
        end
        rst_n = 1'b1;
        idle(1);

        // two wait states: signed/unsigned byte, halfwords, word, illegal funct3, abort
        stall_cnt = 0;
        access(0, 1'b0, 3'd0, 12'h003, 32'h0);
        idle(1);
        chk("lb_stall_cycles", stall_cnt, 2);
        chk("lb_rdata", rdata_o[0], 32'hFFFF_FF80);
        access(0, 1'b0, 3'd4, 12'h003, 32'h0);
        idle(1);
        chk("lbu_rdata", rdata_o[0], 32'h0000_0080);
        access(0, 1'b0, 3'd1, 12'h000, 32'h0);
        access(0, 1'b0, 3'd5, 12'h002, 32'h0);
        access(0, 1'b0, 3'd2, 12'h000, 32'h0);
        idle(1);
        access(0, 1'b0, 3'd3, 12'h000, 32'h0);
        idle(1);
        access(0, 1'b0, 3'd0, 12'h001, 32'h0, 1);
        idle(1);
        chk("abort_rdata_hold", rdata_o[0], 32'h80FF_7F01);

        // combinational RAM with byte enables
        stall_cnt = 0;
        access(1, 1'b0, 3'd1, 12'h002, 32'h0);
        idle(1);
        chk("lh_no_stall", stall_cnt, 0);
        chk("lh_rdata", rdata_o[1], 32'hFFFF_80FF);
        err_cnt = 0;
        access(1, 1'b0, 3'd2, 12'h001, 32'h0);
        idle(1);
        chk("lw_misaligned_err", err_cnt, 1);
        access(1, 1'b1, 3'd1, 12'h002, 32'h1234_BEEF);
        idle(1);
        chk("sh_direct_mem", mem[1][0], 32'hBEEF_7F01);
        access(1, 1'b1, 3'd4, 12'h000, 32'h55);
        access(1, 1'b1, 3'd0, 12'h001, 32'h5A);
        access(1, 1'b1, 3'd2, 12'h004, 32'hDEAD_C0DE);
        access(1, 1'b0, 3'd2, 12'h000, 32'h0);
        access(1, 1'b0, 3'd2, 12'h004, 32'h0);
        idle(1);
        chk("sb_direct_mem", mem[1][0], 32'hBEEF_5A01);

        // read-modify-write with one wait state
        stall_cnt = 0;
        wc = wr_count[2];
        access(2, 1'b1, 3'd0, 12'h001, 32'h0000_00AB);
        idle(1);
        chk("rmw_sb_stall_cycles", stall_cnt, 2);
        chk("rmw_sb_writes", wr_count[2] - wc, 1);
        chk("rmw_sb_mem", mem[2][0], 32'h1122_AB44);
        access(2, 1'b1, 3'd1, 12'h002, 32'h0000_5566);
        access(2, 1'b0, 3'd2, 12'h000, 32'h0);
        idle(1);
        chk("rmw_sh_mem", mem[2][0], 32'h5566_AB44);
        wc = wr_count[2];
        access(2, 1'b1, 3'd0, 12'h002, 32'hEE, 1);
        idle(1);
        access(2, 1'b1, 3'd0, 12'h002, 32'hEE, 2);
        idle(1);
        chk("rmw_abort_writes", wr_count[2] - wc, 0);
        chk("rmw_abort_mem", mem[2][0], 32'h5566_AB44);
        access(2, 1'b1, 3'd2, 12'h008, 32'h0BAD_F00D);
        idle(1);

        // reset in the first stall cycle of a read-modify-write
        wc = wr_count[2];
        chk_en = 1'b0;
        sel = 2; we = 1'b1; f3 = 3'd0; addr = 12'h00D; wdata = 32'h77; req = 1'b1;
        #2;
        chk("rst_pre_stall", stall_o[2], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_stall", stall_o[2], 1'b0);
        chk("rst_oe", oe_o[2], 1'b0);
        chk("rst_wr", wr_o[2], 1'b0);
        chk("rst_err", err_o[2], 1'b0);
        chk("rst_rdata", rdata_o[2], 32'h0);
        chk("rst_ram_addr", ram_addr[2], 10'd0);
        chk("rst_ram_din", ram_din[2], 32'h0);
        chk("rst_ram_be", ram_be[2], 4'h0);
        req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int g = 0; g < NCFG; g++) hold[g] = 32'h0;
        idle(2);
        chk("rst_no_write", wr_count[2] - wc, 0);
        chk("rst_mem_kept", mem[2][3], 32'hCAFE_F00D);
        chk("rst_state_idle", state_o[2], 2'd0);
        access(2, 1'b0, 3'd2, 12'h00C, 32'h0);
        access(2, 1'b1, 3'd0, 12'h00D, 32'h77);
        idle(1);
        chk("post_rst_sb_mem", mem[2][3], 32'hCAFE_770D);

        // eight back-to-back word loads
        stall_cnt = 0;
        for (int k = 0; k < 8; k++) access(2, 1'b0, 3'd2, 12'(16 + 4 * k), 32'h0);
        idle(1);
        chk("b2b_stall_cycles", stall_cnt, 8);
        chk("b2b_last_rdata", rdata_o[2], (32'h0101_0101 * 11) ^ 32'h8040_2010);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Parametrised data-memory bridge between the RISC-V core's load/store port and the data RAM. It decodes the load/store width from funct3 and handles byte, halfword and word accesses with sign/zero extension. It supports a RAM with a configurable read latency, and performs read-modify-write for sub-word stores when the RAM has no byte enables. The core is stalled for the exact number of extra cycles each access needs.

## Interface

Parameters:
- ADDR_W, 12: core byte-address width; RAM word address is ADDR_W-2 bits.
- WAIT_STATES, 1: RAM read latency in cycles, 0..7. 0 means combinational read.
- RMW, 1: 1 = RAM has no byte enables, so sub-word stores use read-modify-write; 0 = byte enables are used directly.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- CORE_REQ  in  1  access request; held stable by the core while CORE_STALL=1.
- CORE_WE  in  1  1 = store, 0 = load.
- CORE_FUNCT3  in  3  RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- CORE_ADDR  in  ADDR_W  byte address.
- CORE_WDATA  in  32  store data, right-aligned.
- CORE_RDATA  out  32  extended load data; valid in the completion cycle.
- CORE_STALL  out  1  core must hold its pipeline.
- CORE_ERR  out  1  misaligned access or illegal funct3; one-cycle pulse.
- RAM_ADDRESS  out  ADDR_W-2  word address.
- RAM_DATA_IN  out  32  write data, lane-aligned.
- RAM_DATA_OUT  in  32  read data.
- RAM_OE  out  1  read enable.
- RAM_WR  out  1  write strobe; the write happens on the edge ending the cycle.
- RAM_BE  out  4  byte enables. Driven 4'hF for every write when RMW=1.

## Operation

- Every output is 0 while RST_n=0.
- FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WR.
- Reset (asynchronous) forces IDLE, clears the wait counter and clears the merge register.
- Legality:
  - Loads: funct3 must be 0, 1, 2, 4 or 5.
  - Stores: funct3 must be 0, 1 or 2.
  - Halfword access needs ADDR[0]=0. Word access needs ADDR[1:0]=0.
  - An illegal request in IDLE gives CORE_ERR=1 for that cycle, with CORE_STALL=0, no RAM_OE and no RAM_WR. The core is expected to drop REQ.
- Byte lane: lane = ADDR[1:0].
  - RAM_DATA_IN replicates the byte or halfword into its lane.
  - Byte enables: 4'b0001<<lane for bytes, 4'b0011<<lane for halfwords, 4'hF for words.
- Load extension: the lane is extracted from RAM_DATA_OUT.
  - LB/LH sign-extend from bit 7 or bit 15.
  - LBU/LHU zero-fill.
  - LW passes the word through.
- Loads:
  - IDLE: RAM_OE=1 and RAM_ADDRESS=ADDR[ADDR_W-1:2] are driven from the request cycle until completion.
  - WAIT_STATES=0: completes in the same cycle, CORE_STALL=0.
  - WAIT_STATES>0: go to RD_WAIT. The counter runs WAIT_STATES cycles. CORE_STALL=1 for the first WAIT_STATES cycles of the access.
  - In the completion cycle, CORE_RDATA is valid, CORE_STALL=0, and the FSM returns to IDLE.
- Word store, or any store with RMW=0: RAM_WR=1 in the request cycle, CORE_STALL=0, FSM stays in IDLE.
- Sub-word store with RMW=1:
  - Read phase: RAM_OE=1 for WAIT_STATES+1 cycles, through RMW_WAIT when WAIT_STATES>0. The final read cycle captures RAM_DATA_OUT with the new lane merged in.
  - RMW_WR: RAM_WR=1 with the merged word, RAM_BE=4'hF, CORE_STALL=0.
  - CORE_STALL=1 during the whole read phase.
- Abort: if CORE_REQ falls while in RD_WAIT or RMW_WAIT, or before RMW_WR, go to IDLE next cycle with no RAM_WR.
- Back-to-back: a new request is accepted in the cycle after completion. There are no bubbles beyond the stall counts above.
- CORE_RDATA holds its last load value when no load completes. It is 0 after reset.

## Timing

- Load latency: WAIT_STATES cycles of stall. Results are available in cycle WAIT_STATES counted from the request cycle (cycle 0).
- Word store: 0 stall cycles.
- Sub-word store: 0 stall cycles when RMW=0, WAIT_STATES+1 stall cycles when RMW=1.
- CORE_STALL and CORE_ERR are combinational from state, the counter and the request decode. They are never registered versions of the request.
- RAM_DATA_OUT is sampled only in the final read cycle. Earlier values are ignored.
- Reset asserted mid-access:
  - All outputs drop to 0 immediately.
  - No RAM_WR is issued.
  - After release the FSM is in IDLE and the first edge can accept a request.

## Test plan

- WAIT_STATES=2, RAM word 0x000 = 0x80FF_7F01, LB at 0x003 -> STALL high for 2 cycles, then RDATA=0xFFFF_FF80. LBU at 0x003 -> RDATA=0x0000_0080.
- WAIT_STATES=0, LH at 0x002 with word 0x80FF_7F01 -> no stall, same-cycle RDATA=0xFFFF_80FF. LW at 0x001 -> ERR pulse, no RAM_OE.
- RMW=1, WAIT_STATES=1, word 0x1122_3344, SB 0xAB at 0x001 -> STALL 2 cycles, then one RAM_WR with 0x1122_AB44 and BE=4'hF.
- RMW=0, SH 0xBEEF at 0x002 -> RAM_WR in the same cycle, BE=4'b1100, DATA_IN[31:16]=0xBEEF, STALL=0.
- RMW=1 SB in progress, RST_n pulled low in the first stall cycle -> all outputs 0, no write, memory word unchanged, next request serviced normally.
- 8 back-to-back LW at WAIT_STATES=1 -> exactly 8 stall cycles over 16 total cycles, all data correct.
